pyth_triple_gen: RTL
====================

PYTH_TRIPLE_GEN -- requirements
Module: pyth_triple_gen

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the width of each triple component.
REQ-002 The block SHALL have parameter MAX, default 20, giving the largest value of a, b or c enumerated; MAX SHALL satisfy 5 <= MAX <= 2**W-1.
REQ-003 The block SHALL have parameter CW, default 16, giving the width of the triple counter.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: a pulse that starts one enumeration run.
REQ-007 The block SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the run completes.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a triple is presented.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the triple.
REQ-011 The block SHALL have ports out_a, out_b and out_c, outputs, W bits each: the triple components.
REQ-012 The block SHALL have port count, output, CW bits: the number of triples accepted in the current run.

Function
REQ-013 The block SHALL emit every integer triple with 1 <= a <= b < c <= MAX and a*a + b*b == c*c exactly once per run.
REQ-014 Emission order SHALL be ascending a, then ascending b.
REQ-015 The FSM SHALL have states IDLE, CALC, SEARCH, EMIT, ADV and DONE.
REQ-016 In IDLE with start=1, the block SHALL set a=1, b=1, count=0 and enter CALC; start SHALL be ignored in every other state.
REQ-017 CALC SHALL take one cycle: register s = a*a + b*b at width 2W+1 with no truncation, load c = b+1 and enter SEARCH.
REQ-018 In SEARCH, one candidate c SHALL be tested per cycle.
REQ-019 In SEARCH, c*c == s SHALL cause entry to EMIT.
REQ-020 In SEARCH, c*c > s, or c == MAX with no match, SHALL cause entry to ADV.
REQ-021 In SEARCH, any other result SHALL increment c.
REQ-022 If b+1 > MAX on entry to SEARCH, the block SHALL go directly to ADV.
REQ-023 In EMIT, out_valid SHALL be 1 and out_a, out_b and out_c SHALL hold a, b and c stable until out_valid && out_ready.
REQ-024 On the handshake cycle, count SHALL increment and the FSM SHALL enter ADV; out_valid SHALL be 0 in the following cycle.
REQ-025 out_valid SHALL NOT drop without a handshake (no retraction).
REQ-026 In ADV with b < MAX, the block SHALL increment b.
REQ-027 In ADV with b == MAX and a < MAX, the block SHALL set a=a+1 and b=a+1 (the new a).
REQ-028 In ADV, the next state SHALL be CALC; if a == MAX and b == MAX, the next state SHALL be DONE instead.
REQ-029 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-030 count SHALL hold its final value in IDLE until the next accepted start.
REQ-031 busy SHALL be 1 in CALC, SEARCH, EMIT and ADV, and 0 in IDLE and DONE.
REQ-032 out_ready while out_valid=0 SHALL have no effect.
REQ-033 count SHALL saturate at 2**CW-1.

Reset
REQ-034 With rst=1 at a rising edge, the FSM SHALL enter IDLE and a, b, c, s and count SHALL clear to 0.
REQ-035 After reset, out_valid, done and busy SHALL be 0 and out_a, out_b and out_c SHALL be 0.
REQ-036 rst SHALL take priority over start and over a simultaneous handshake.
REQ-037 Reset mid-run, including during EMIT, SHALL abort the run with no further triple emitted and no done pulse.

Verification
REQ-038 MAX=20, out_ready=1, pulse start: the bench SHALL see the triples in order (3,4,5), (5,12,13), (6,8,10), (8,15,17), (9,12,15), (12,16,20), then done, then count=6 and busy=0.
REQ-039 MAX=5, pulse start: the bench SHALL see exactly one triple (3,4,5), then done, then count=1.
REQ-040 MAX=20 with out_ready held 0 for 7 cycles during the first EMIT: out_valid SHALL stay 1 with (3,4,5) stable and count=0; after out_ready rises, count SHALL be 1 and the full sequence SHALL still complete.
REQ-041 Start pulsed again while busy: the bench SHALL see no effect on the sequence or count; start after done SHALL begin a new run with count reset to 0.
REQ-042 rst asserted while presenting (5,12,13): the next cycle SHALL show out_valid=0, busy=0 and count=0, and no done SHALL occur; a fresh start SHALL emit (3,4,5) first.
REQ-043 Random out_ready (50%) over 3 runs at MAX=20: every run SHALL emit an identical sequence with no drop or duplicate, and outputs SHALL stay stable under backpressure.

Source files
------------

// File: rtl/pyth_triple_gen.sv
// Enumerates Pythagorean triples (a <= b < c <= MAX) in ascending (a, b) order,
// presenting each one on a valid/ready output port and counting accepted triples.
module pyth_triple_gen #(
  parameter int W   = 8,
  parameter int MAX = 20,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_a,
  output logic [W-1:0]  out_b,
  output logic [W-1:0]  out_c,
  output logic [CW-1:0] count,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {IDLE, CALC, SEARCH, EMIT, ADV, DONE} state_t;

  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W:0]   MAX_C = (W+1)'(MAX);

  state_t          state;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [W:0]      c;
  logic [2*W:0]    s;
  logic [2*W:0]    a_ext;
  logic [2*W:0]    b_ext;
  logic [2*W+1:0]  c_ext;
  logic [2*W+1:0]  c_sq;

  // c carries one extra bit so b+1 cannot wrap when b == MAX == 2**W-1.
  assign a_ext     = {{(W+1){1'b0}}, a};
  assign b_ext     = {{(W+1){1'b0}}, b};
  assign c_ext     = {{(W+1){1'b0}}, c};
  assign c_sq      = c_ext * c_ext;
  assign state_dbg = state;

  // Output handshake: a triple transfers on any rising edge where out_valid and
  // out_ready are both high; out_valid never drops before that edge and
  // out_a/out_b/out_c stay frozen while it waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      s         <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_c     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a     <= W'(1);
            b     <= W'(1);
            count <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          s     <= a_ext * a_ext + b_ext * b_ext;
          c     <= {1'b0, b} + (W+1)'(1);
          state <= SEARCH;
        end
        SEARCH: begin
          if (c > MAX_C) begin
            state <= ADV;
          end else if (c_sq == {1'b0, s}) begin
            out_valid <= 1'b1;
            out_a     <= a;
            out_b     <= b;
            out_c     <= c[W-1:0];
            state     <= EMIT;
          end else if (c_sq > {1'b0, s} || c == MAX_C) begin
            state <= ADV;
          end else begin
            c <= c + (W+1)'(1);
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (count != '1) count <= count + CW'(1);
            state <= ADV;
          end
        end
        ADV: begin
          if (b < MAX_V) begin
            b <= b + W'(1);
          end else if (a < MAX_V) begin
            a <= a + W'(1);
            b <= a + W'(1);
          end
          if (a == MAX_V && b == MAX_V) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= CALC;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
